control_unit: RTL

//   Multicycle FSM that sequences the accumulator datapath around the 11-bit add/sub alu.

---
 rtl/control_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multicycle sequencer for the accumulator datapath.
// Fetch/decode/execute with memory ready handshake and flag branches.
module control_unit #(
  parameter int OPCODE_WIDTH = 5,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clock_in,
  input  logic                    reset_n_in,
  input  logic [OPCODE_WIDTH-1:0] opcode_in,
  input  logic                    zero_indicator_in,
  input  logic                    signal_bit_in,
  input  logic                    mem_ready_in,
  output logic                    mem_read_out,
  output logic                    mem_write_out,
  output logic                    ir_enable_out,
  output logic                    pc_enable_out,
  output logic                    pc_load_out,
  output logic                    acc_enable_out,
  output logic [1:0]              acc_sel_out,
  output logic                    b_sel_out,
  output logic                    operation_out,
  output logic                    flags_enable_out,
  output logic                    halted_out,
  output logic [2:0]              state_out,
  output logic [COUNT_WIDTH-1:0]  instr_count_out
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int OW = OPCODE_WIDTH;

  logic [2:0] state, state_nx;
  logic [COUNT_WIDTH-1:0] count;

  logic is_hlt, is_sto, is_ld, is_ldi;
  logic is_add, is_addi, is_sub, is_subi;
  logic is_beq, is_bne, is_bgt, is_blt, is_jmp;
  logic mem_op, retire;

  // Opcode decode into one-hot flags
  always_comb begin
    is_hlt  = opcode_in == OW'(0);
    is_sto  = opcode_in == OW'(1);
    is_ld   = opcode_in == OW'(2);
    is_ldi  = opcode_in == OW'(3);
    is_add  = opcode_in == OW'(4);
    is_addi = opcode_in == OW'(5);
    is_sub  = opcode_in == OW'(6);
    is_subi = opcode_in == OW'(7);
    is_beq  = opcode_in == OW'(8);
    is_bne  = opcode_in == OW'(9);
    is_bgt  = opcode_in == OW'(10);
    is_blt  = opcode_in == OW'(11);
    is_jmp  = opcode_in == OW'(12);
    mem_op  = is_sto | is_ld | is_add | is_sub;
    retire  = (state == S_EXEC) &&
              (!mem_op || mem_ready_in);
  end

  // State register
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= S_INIT;
    else             state <= state_nx;
  end

  // Retired-instruction counter, saturating
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)
      count <= '0;
    else if (retire && count != '1)
      count <= count + 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_nx = S_INIT;
    unique case (state)
      S_INIT:  state_nx = S_FETCH;
      S_FETCH: state_nx = mem_ready_in ? S_DEC : S_FETCH;
      S_DEC:   state_nx = is_hlt ? S_HALT : S_EXEC;
      S_EXEC:  state_nx = retire ? S_FETCH : S_EXEC;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_INIT;
    endcase
  end

  // Output decode from state, opcode and ready
  always_comb begin
    mem_read_out     = 1'b0;
    mem_write_out    = 1'b0;
    ir_enable_out    = 1'b0;
    pc_enable_out    = 1'b0;
    pc_load_out      = 1'b0;
    acc_enable_out   = 1'b0;
    acc_sel_out      = 2'b00;
    b_sel_out        = 1'b0;
    operation_out    = 1'b0;
    flags_enable_out = 1'b0;
    if (state == S_FETCH) begin
      mem_read_out  = 1'b1;
      ir_enable_out = mem_ready_in;
      pc_enable_out = mem_ready_in;
    end else if (state == S_EXEC) begin
      unique case (1'b1)
        is_sto: mem_write_out = 1'b1;
        is_ld: begin
          mem_read_out   = 1'b1;
          acc_sel_out    = 2'b01;
          acc_enable_out = mem_ready_in;
        end
        is_ldi: begin
          acc_sel_out    = 2'b10;
          acc_enable_out = 1'b1;
        end
        is_add, is_sub: begin
          mem_read_out     = 1'b1;
          operation_out    = is_sub & mem_ready_in;
          acc_enable_out   = mem_ready_in;
          flags_enable_out = mem_ready_in;
        end
        is_addi, is_subi: begin
          b_sel_out        = 1'b1;
          operation_out    = is_subi;
          acc_enable_out   = 1'b1;
          flags_enable_out = 1'b1;
        end
        is_beq: pc_load_out = zero_indicator_in;
        is_bne: pc_load_out = !zero_indicator_in;
        is_bgt: pc_load_out = !zero_indicator_in &&
                              !signal_bit_in;
        is_blt: pc_load_out = signal_bit_in;
        is_jmp: pc_load_out = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted_out      = state == S_HALT;
  assign state_out       = state;
  assign instr_count_out = count;

endmodule
